// File: rtl/ro_array_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator array frequency meter.
package ro_meter_pkg;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Two synchroniser flops plus the edge-detector history flop.
    localparam int SYNC_DEPTH = 3;

    // Width of the channel select; a single channel still gets one bit.
    function automatic int sel_width(input int num_ro);
        return (num_ro > 1) ? $clog2(num_ro) : 1;
    endfunction

endpackage

// File: rtl/ro_array_freq_meter_core.sv
// One enable-gated ring oscillator followed by a ripple prescaler.
// Ring: NAND(en, last stage) then STAGES-1 inverters; held static while en=0.
module ro_core #(
    parameter int STAGES   = 3,
    parameter int DIV_LOG2 = 2
) (
    input  logic en,
    output logic ro_div
);

    (* keep = "true" *) logic              nand_s;
    (* keep = "true" *) logic [STAGES-2:0] inv_s;
    logic [DIV_LOG2:0]                     tap_s;

    assign nand_s   = ~(en & inv_s[STAGES-2]);
    assign inv_s[0] = ~nand_s;

    for (genvar s = 1; s < STAGES - 1; s++) begin : g_inv
        assign inv_s[s] = ~inv_s[s-1];
    end

    assign tap_s[0] = inv_s[STAGES-2];

    for (genvar j = 0; j < DIV_LOG2; j++) begin : g_div
        logic t_q;

        // Toggle flop clocked by the previous tap, held clear while the ring is off.
        always_ff @(posedge tap_s[j] or negedge en) begin
            if (!en) begin
                t_q <= 1'b0;
            end else begin
                t_q <= ~t_q;
            end
        end

        assign tap_s[j+1] = t_q;
    end

    assign ro_div = tap_s[DIV_LOG2];

endmodule

// File: rtl/ro_array_freq_meter.sv
// Array of gated ring oscillators with a windowed edge-counting frequency meter.
module ro_array_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int NUM_RO   = 4,
    parameter int STAGES   = 3,
    parameter int DIV_LOG2 = 2,
    parameter int GATE_W   = 16,
    parameter int CNT_W    = 16,
    parameter int SETTLE   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          continuous,
    input  logic [sel_width(NUM_RO)-1:0]  ro_sel,
    input  logic [GATE_W-1:0]             gate_cycles,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              count,
    output logic                          overflow,
    output logic                          ro_out
);

    localparam int SEL_W = sel_width(NUM_RO);
    localparam int TMR_W = (GATE_W > $clog2(SETTLE + 1)) ? GATE_W : $clog2(SETTLE + 1);

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [SEL_W-1:0]        sel_q, sel_d, sel_in_s;
    logic [GATE_W-1:0]       gate_q, gate_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, count_q, count_d;
    logic                    flag_q, flag_d, ovf_q, ovf_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [NUM_RO-1:0]       en_q, en_d;
    logic [NUM_RO-1:0]       div_s;
    logic [SYNC_DEPTH-1:0]   sync_q;
    logic                    meas_in_s, edge_s;

    for (genvar k = 0; k < NUM_RO; k++) begin : g_ro
        ro_core #(
            .STAGES   (STAGES),
            .DIV_LOG2 (DIV_LOG2)
        ) u_core (
            .en     (en_q[k]),
            .ro_div (div_s[k])
        );
    end

    // Only the enabled channel can reach the output and the meter.
    assign meas_in_s = |(en_q & div_s);
    assign ro_out    = meas_in_s;
    assign edge_s    = sync_q[SYNC_DEPTH-2] & ~sync_q[SYNC_DEPTH-1];

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        if (int'(ro_sel) >= NUM_RO) begin
            sel_in_s = '0;
        end else begin
            sel_in_s = ro_sel;
        end
    end

    // Sequencer next state, window timer, saturating counter and registered outputs.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        sel_d   = sel_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        en_d    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = sel_in_s;
                    gate_d  = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
                    tmr_d   = TMR_W'(SETTLE - 1);
                    state_d = WARMUP;
                end else begin
                    state_d = IDLE;
                end
            end
            WARMUP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
                    state_d = MEASURE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (edge_s) begin
                        if (cnt_q == {CNT_W{1'b1}}) begin
                            flag_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (tmr_q == '0) begin
                        tmr_d   = TMR_W'(2);
                        state_d = DRAIN;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            DONE: begin
                count_d = cnt_q;
                ovf_d   = flag_q;
                done_d  = 1'b1;
                if (continuous) begin
                    tmr_d   = TMR_W'(SETTLE - 1);
                    state_d = WARMUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == WARMUP) || (state_d == MEASURE) || (state_d == DRAIN);
        for (int i = 0; i < NUM_RO; i++) begin
            en_d[i] = ((state_d == WARMUP) || (state_d == MEASURE)) && (int'(sel_d) == i);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            sel_q   <= '0;
            gate_q  <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sel_q   <= sel_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    // Synchroniser and edge-history flops for the selected oscillator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], meas_in_s};
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: doc/ro_array_freq_meter.md
Name: ro_array_freq_meter

Overview:
- Parametrised successor to the single gated ring oscillator: an array of NUM_RO enable-gated ring oscillators with configurable odd stage count.
- Exactly one channel is enabled at a time and routed to ro_out.
- An on-chip frequency meter counts the selected channel's edges over a programmable window of clk cycles.
- Sits between the tile's I/O wrapper (start, select and gate inputs) and the result readout; replaces the free-running enable-only oscillator.

Parameters:
- NUM_RO, 4: number of oscillator channels; must be ≥1.
- STAGES, 3: inverting stages per ring; must be odd and ≥3.
- DIV_LOG2, 2: ripple prescaler in the RO domain; the edge rate seen by clk is f_ro / 2^DIV_LOG2.
- GATE_W, 16: width of the gate-window length.
- CNT_W, 16: width of the result counter.
- SETTLE, 8: clk cycles between oscillator enable and window open.

Ports:
- clk  input  1  sole synchronous clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle measurement request.
- abort  input  1  cancels a measurement in progress.
- continuous  input  1  when 1, automatically re-arm after DONE.
- ro_sel  input  max(1,$clog2(NUM_RO))  channel select; latched at start.
- gate_cycles  input  GATE_W  window length in clk cycles; latched at start; 0 is treated as 1.
- busy  output  1  high in WARMUP, MEASURE and DRAIN.
- done  output  1  one-cycle pulse when the result becomes valid.
- count  output  CNT_W  last completed result; held stable between done pulses.
- overflow  output  1  count saturated during the last window.
- ro_out  output  1  selected prescaled oscillator output; 0 when no channel is enabled.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all ring enables 0.
  - busy=0, done=0, count=0, overflow=0, ro_out=0.
  - Prescaler and synchroniser flops cleared.
- Ring structure:
  - Ring k is a NAND(en_k, last stage) followed by STAGES-1 keep-attributed inverters.
  - en_k is a registered clk-domain flop. Disabled rings hold a static level.
  - The prescaler is a ripple chain of DIV_LOG2 toggle flops clocked by the ring and cleared asynchronously while en_k=0.
- Crossing: the selected prescaler output passes through a 2-flop synchroniser and then a rising-edge detector in the clk domain.
- FSM states and transitions:
  - IDLE: on start, latch sel and gate (gate 0 becomes 1), set en[sel]=1, load timer=SETTLE-1, go to WARMUP.
  - WARMUP: decrement timer. At 0, clear the counter, load timer=gate-1, go to MEASURE.
  - MEASURE: each detected edge increments the counter. The counter saturates at 2^CNT_W-1 and sets the overflow flag. At timer 0 (the last window cycle still counts an edge), go to DRAIN.
  - DRAIN: clear en, wait 3 cycles to flush the synchroniser with no counting, then go to DONE.
  - DONE: count ← counter and overflow ← flag, both registered together with done=1 for exactly one cycle. Next state is WARMUP with the same latched sel/gate if continuous=1, otherwise IDLE.
- Latency: start to done = SETTLE + gate + 3 + 1 cycles.
- Start while busy: ignored; the latched sel and gate are unchanged.
- Abort:
  - Accepted in WARMUP, MEASURE or DRAIN.
  - Next cycle: en cleared, state IDLE, no done pulse.
  - count and overflow keep their previous values.
  - abort has priority over every other transition, including a simultaneous start.
- Continuous mode: deasserting continuous mid-window finishes the current window and then returns to IDLE.
- Out-of-range ro_sel (≥ NUM_RO): treated as channel 0.
- Reset mid-operation: all state returns to reset values immediately; the rings stop.

Decomposition:
- Package ro_meter_pkg holds:
  - state enum {IDLE, WARMUP, MEASURE, DRAIN, DONE};
  - localparam SYNC_DEPTH=3 (synchroniser plus edge detector);
  - a function for clog2 of the select width.
- Sub-module ro_core (parameter STAGES, DIV_LOG2; ports en, ro_div) holds the ring and prescaler with keep attributes. It is instantiated NUM_RO times with generate.

Test Plan:
- Bench stimulus: behavioural ro_core model with period 40 ns, DIV_LOG2=0, clk 10 ns.
- Basic measurement: reset, then start with ro_sel=1 and gate_cycles=100.
  - busy rises the next cycle; done pulses exactly 112 cycles after start.
  - count in 24..26; overflow=0.
- Saturation: CNT_W=4 build, gate_cycles=200 → count=15, overflow=1.
- Abort: abort asserted 20 cycles after start → busy=0 the next cycle, no done, count keeps its prior value, and ro_out=0 within 1 cycle.
- Continuous mode: continuous=1, gate_cycles=40 → done pulses spaced 52 cycles apart. Drop continuous → one further done, then IDLE.
- Ignored start and channel isolation: start pulsed during MEASURE with ro_sel=3 → ignored, result still from channel 1. Only en[1] is ever high during the run.
- Reset: rst_n low mid-MEASURE → all outputs 0 asynchronously. After release, gate_cycles=0 yields latency SETTLE+1+3+1=13.
